// File: rtl/vpu_mem_pkg.sv
// ----------------------------------------------------------------------------
// vpu_mem_pkg
// Shared definitions for the video object memory path. The matrix unit,
// clipping unit and video_mem_unit all use these definitions.
//   OBJ_ADDR_W : object memory address width (32 entries)
//   OBJ_DATA_W : object memory word width
//   rd_owner_t : which requester owns the read data returning next cycle
// ----------------------------------------------------------------------------
package vpu_mem_pkg;

    localparam int OBJ_ADDR_W = 5;
    localparam int OBJ_DATA_W = 144;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        M    = 2'd1,
        C    = 2'd2
    } rd_owner_t;

endpackage : vpu_mem_pkg

// File: rtl/arb_starve_ctr.sv
// ----------------------------------------------------------------------------
// arb_starve_ctr
// Saturating counter of consecutive denied clipper cycles.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   i_inc : count one more denied cycle (holds at LIMIT)
//   i_clr : clear the count; wins over i_inc
//   o_hit : count has reached LIMIT
// ----------------------------------------------------------------------------
module arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    logic [CNT_W-1:0] r_cnt;

    // Denied-cycle counter: clear has priority, then saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_W'(LIMIT))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_hit = (r_cnt == CNT_W'(LIMIT));

endmodule : arb_starve_ctr

// File: rtl/obj_mem_arbiter.sv
// ----------------------------------------------------------------------------
// obj_mem_arbiter
// Arbitrates the single-port object memory between the matrix unit
// (reads/writes) and the clipper (reads). One access per cycle; grants and
// mem_* are combinational, read data returns one cycle later with a tagged
// valid.
//   clk, rst                 : clock, synchronous active-high reset
//   m_req/m_we/m_addr/m_wdata: matrix request
//   m_gnt, m_rvalid          : matrix grant, matrix read data valid
//   m_stalled                : matrix request denied this cycle
//   c_req/c_lock/c_addr      : clipper read request and frame lock
//   c_gnt, c_rvalid          : clipper grant, clipper read data valid
//   rdata                    : shared read data (memory passthrough)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port
// ----------------------------------------------------------------------------
module obj_mem_arbiter
    import vpu_mem_pkg::*;
#(
    parameter int ADDR_W       = OBJ_ADDR_W,
    parameter int DATA_W       = OBJ_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_gnt,
    output logic              m_rvalid,
    input  logic              c_req,
    input  logic              c_lock,
    input  logic [ADDR_W-1:0] c_addr,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_stalled
);

    logic      w_starve_hit;
    logic      w_m_gnt;
    logic      w_c_gnt;
    rd_owner_t r_rd_owner;

    // Grant selection. Reset forces both grants low so nothing reaches memory.
    always_comb begin
        w_m_gnt = 1'b0;
        w_c_gnt = 1'b0;
        if (rst) begin
            w_m_gnt = 1'b0;
            w_c_gnt = 1'b0;
        end else if (w_starve_hit && c_req) begin
            w_c_gnt = 1'b1;
        end else if (c_lock && c_req) begin
            w_c_gnt = 1'b1;
        end else if (c_lock && m_req && m_we) begin
            // Frame lock holds off matrix writes; c_req is low here, so idle.
            w_m_gnt = 1'b0;
        end else if (m_req) begin
            w_m_gnt = 1'b1;
        end else if (c_req) begin
            w_c_gnt = 1'b1;
        end else begin
            w_m_gnt = 1'b0;
            w_c_gnt = 1'b0;
        end
    end

    // A withdrawn or granted clipper request restarts the starvation count.
    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (c_req && !w_c_gnt),
        .i_clr (!c_req || w_c_gnt),
        .o_hit (w_starve_hit)
    );

    // Read tag: records who owns the memory output in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_owner <= NONE;
        end else if (w_m_gnt && !m_we) begin
            r_rd_owner <= M;
        end else if (w_c_gnt) begin
            r_rd_owner <= C;
        end else begin
            r_rd_owner <= NONE;
        end
    end

    assign m_gnt     = w_m_gnt;
    assign c_gnt     = w_c_gnt;
    assign m_stalled = !rst && m_req && !w_m_gnt;

    // Valids are masked during reset so a read in flight is dropped.
    assign m_rvalid  = !rst && (r_rd_owner == M);
    assign c_rvalid  = !rst && (r_rd_owner == C);
    assign rdata     = mem_rdata;

    assign mem_en    = w_m_gnt || w_c_gnt;
    assign mem_we    = w_m_gnt && m_we;
    assign mem_addr  = w_c_gnt ? c_addr : m_addr;
    assign mem_wdata = (w_m_gnt && m_we) ? m_wdata : '0;

endmodule : obj_mem_arbiter

// File: tb/tb_obj_mem_arbiter.sv
module tb_obj_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_req, m_we, m_gnt, m_rvalid, m_stalled;
    logic [4:0]   m_addr;
    logic [143:0] m_wdata;
    logic         c_req, c_lock, c_gnt, c_rvalid;
    logic [4:0]   c_addr;
    logic [143:0] rdata;
    logic         mem_en, mem_we;
    logic [4:0]   mem_addr;
    logic [143:0] mem_wdata, mem_rdata;

    logic [143:0] mem_model [32];
    int           n_tests = 0;
    int           n_fail  = 0;

    localparam logic [143:0] PAT_A5 = {18{8'hA5}};
    localparam logic [143:0] PAT_7  = {9{16'h7E57}};

    always #5 clk = ~clk;

    obj_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid),
        .c_req(c_req), .c_lock(c_lock), .c_addr(c_addr),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .m_stalled(m_stalled)
    );

    // Single-port memory with registered read output
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    function automatic logic [143:0] pat(input int i);
        logic [15:0] w;
        w = 16'hC000 | 16'(i);
        return {9{w}};
    endfunction

    // Contents written by this bench before the clipper burst
    function automatic logic [143:0] exp_data(input int i);
        if (i == 3)      return PAT_A5;
        else if (i == 7) return PAT_7;
        else             return pat(i);
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m_req = 1'b0; m_we = 1'b0; m_addr = 5'd0; m_wdata = 144'd0;
        c_req = 1'b0; c_lock = 1'b0; c_addr = 5'd0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        // Reset with a matrix write pending: must be suppressed
        m_req = 1'b1; m_we = 1'b1; m_addr = 5'd9; m_wdata = PAT_A5;
        mid();
        chk("rst_m_gnt", 144'(m_gnt), 144'd0);
        chk("rst_c_gnt", 144'(c_gnt), 144'd0);
        chk("rst_mem_en", 144'(mem_en), 144'd0);
        chk("rst_mem_we", 144'(mem_we), 144'd0);
        chk("rst_m_stalled", 144'(m_stalled), 144'd0);
        cyc();
        cyc();
        rst = 1'b0;
        idle_inputs();
        mid();
        chk("post_rst_m_rvalid", 144'(m_rvalid), 144'd0);
        chk("post_rst_c_rvalid", 144'(c_rvalid), 144'd0);
        chk("idle_mem_en", 144'(mem_en), 144'd0);
        cyc();

        // Fill memory through the matrix port
        for (int i = 0; i < 32; i++) begin
            m_req = 1'b1; m_we = 1'b1; m_addr = 5'(i); m_wdata = pat(i);
            mid();
            chk("fill_m_gnt", 144'(m_gnt), 144'd1);
            cyc();
        end

        // Matrix write addr 3 = A5...
        m_req = 1'b1; m_we = 1'b1; m_addr = 5'd3; m_wdata = PAT_A5;
        mid();
        chk("wr3_m_gnt", 144'(m_gnt), 144'd1);
        chk("wr3_mem_en", 144'(mem_en), 144'd1);
        chk("wr3_mem_we", 144'(mem_we), 144'd1);
        chk("wr3_mem_addr", 144'(mem_addr), 144'd3);
        chk("wr3_mem_wdata", mem_wdata, PAT_A5);
        cyc();
        // Matrix read addr 3
        m_we = 1'b0;
        mid();
        chk("rd3_m_gnt", 144'(m_gnt), 144'd1);
        chk("rd3_m_rvalid_after_wr", 144'(m_rvalid), 144'd0);
        chk("rd3_mem_we", 144'(mem_we), 144'd0);
        cyc();
        // Back-to-back reads 4 and 5 while addr 3 data returns
        m_addr = 5'd4;
        mid();
        chk("rd3_m_rvalid", 144'(m_rvalid), 144'd1);
        chk("rd3_c_rvalid", 144'(c_rvalid), 144'd0);
        chk("rd3_rdata", rdata, PAT_A5);
        cyc();
        m_addr = 5'd5;
        mid();
        chk("rd4_m_rvalid", 144'(m_rvalid), 144'd1);
        chk("rd4_rdata", rdata, pat(4));
        cyc();
        m_req = 1'b0;
        mid();
        chk("rd5_m_rvalid", 144'(m_rvalid), 144'd1);
        chk("rd5_rdata", rdata, pat(5));
        cyc();
        mid();
        chk("rd_done_m_rvalid", 144'(m_rvalid), 144'd0);
        cyc();

        // Contention: matrix 4 cycles, clipper on the 5th, repeating
        m_req = 1'b1; m_we = 1'b0; m_addr = 5'd1;
        c_req = 1'b1; c_addr = 5'd2;
        for (int k = 0; k < 10; k++) begin
            mid();
            chk("cont_m_gnt", 144'(m_gnt), 144'((k % 5) != 4));
            chk("cont_c_gnt", 144'(c_gnt), 144'((k % 5) == 4));
            chk("cont_m_stalled", 144'(m_stalled), 144'((k % 5) == 4));
            if (k > 0) begin
                chk("cont_m_rvalid", 144'(m_rvalid), 144'(((k - 1) % 5) != 4));
                chk("cont_c_rvalid", 144'(c_rvalid), 144'(((k - 1) % 5) == 4));
                chk("cont_rdata", rdata, (((k - 1) % 5) == 4) ? pat(2) : pat(1));
            end
            cyc();
        end
        idle_inputs();
        cyc();

        // Lock blocks a matrix write to addr 7
        c_lock = 1'b1;
        m_req = 1'b1; m_we = 1'b1; m_addr = 5'd7; m_wdata = PAT_7;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("lock_m_gnt", 144'(m_gnt), 144'd0);
            chk("lock_m_stalled", 144'(m_stalled), 144'd1);
            chk("lock_mem_en", 144'(mem_en), 144'd0);
            cyc();
        end
        c_lock = 1'b0;
        mid();
        chk("unlock_m_gnt", 144'(m_gnt), 144'd1);
        chk("unlock_m_stalled", 144'(m_stalled), 144'd0);
        chk("unlock_mem_addr", 144'(mem_addr), 144'd7);
        chk("unlock_mem_wdata", mem_wdata, PAT_7);
        cyc();
        // Matrix read under lock with no clipper request is granted
        c_lock = 1'b1; m_we = 1'b0;
        mid();
        chk("lock_rd_m_gnt", 144'(m_gnt), 144'd1);
        cyc();
        // Matrix read under lock with clipper requesting: clipper wins
        c_req = 1'b1; c_addr = 5'd6;
        mid();
        chk("lock_rd7_m_rvalid", 144'(m_rvalid), 144'd1);
        chk("lock_rd7_rdata", rdata, PAT_7);
        chk("lock_both_c_gnt", 144'(c_gnt), 144'd1);
        chk("lock_both_m_gnt", 144'(m_gnt), 144'd0);
        cyc();
        idle_inputs();
        cyc();

        // Locked clipper burst over all addresses with a matrix write pending
        c_lock = 1'b1; c_req = 1'b1;
        m_req = 1'b1; m_we = 1'b1; m_addr = 5'd9; m_wdata = 144'd0;
        for (int i = 0; i < 32; i++) begin
            c_addr = 5'(i);
            mid();
            chk("burst_c_gnt", 144'(c_gnt), 144'd1);
            chk("burst_m_gnt", 144'(m_gnt), 144'd0);
            if (i > 0) begin
                chk("burst_c_rvalid", 144'(c_rvalid), 144'd1);
                chk("burst_rdata", rdata, exp_data(i - 1));
            end
            cyc();
        end
        idle_inputs();
        mid();
        chk("burst_last_c_rvalid", 144'(c_rvalid), 144'd1);
        chk("burst_last_rdata", rdata, exp_data(31));
        cyc();

        // Reset on the cycle after a clipper read grant
        c_req = 1'b1; c_addr = 5'd0;
        mid();
        chk("pre_rst_c_gnt", 144'(c_gnt), 144'd1);
        cyc();
        rst = 1'b1; c_req = 1'b0;
        m_req = 1'b1; m_we = 1'b1; m_addr = 5'd0; m_wdata = 144'd0;
        mid();
        chk("midrst_c_rvalid", 144'(c_rvalid), 144'd0);
        chk("midrst_mem_en", 144'(mem_en), 144'd0);
        chk("midrst_m_gnt", 144'(m_gnt), 144'd0);
        cyc();
        rst = 1'b0;
        idle_inputs();
        mid();
        chk("after_rst_c_rvalid", 144'(c_rvalid), 144'd0);
        chk("after_rst_m_rvalid", 144'(m_rvalid), 144'd0);
        chk("after_rst_c_gnt", 144'(c_gnt), 144'd0);
        chk("after_rst_mem_en", 144'(mem_en), 144'd0);
        chk("after_rst_m_stalled", 144'(m_stalled), 144'd0);
        cyc();
        // Addr 0 must not have been overwritten during reset
        m_req = 1'b1; m_we = 1'b0; m_addr = 5'd0;
        cyc();
        m_req = 1'b0;
        mid();
        chk("rst_wr_suppressed", rdata, pat(0));
        cyc();

        // Withdrawal: clipper denied 2 cycles then drops; count restarts
        m_req = 1'b1; m_we = 1'b0; m_addr = 5'd1;
        c_req = 1'b1; c_addr = 5'd2;
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("wd_m_gnt", 144'(m_gnt), 144'd1);
            chk("wd_c_gnt", 144'(c_gnt), 144'd0);
            cyc();
        end
        c_req = 1'b0;
        mid();
        chk("wd_drop_m_gnt", 144'(m_gnt), 144'd1);
        cyc();
        c_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mid();
            chk("wd_c_rvalid", 144'(c_rvalid), 144'd0);
            chk("wd_again_c_gnt", 144'(c_gnt), 144'(k == 4));
            cyc();
        end
        idle_inputs();
        mid();
        chk("wd_final_c_rvalid", 144'(c_rvalid), 144'd1);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_obj_mem_arbiter
